// File: rtl/output_pkg.sv
// output_pkg: FSM state encoding, controller defaults and packer bank base addresses
package output_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BANK,
    S_ARM,
    S_STREAM,
    S_FLUSH,
    S_DONE,
    S_ABORT
  } state_t;
  localparam int BYTES_PER_FRAME_DEF = 1024;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam logic [15:0] BANK0_BASE = 16'h0000;
  localparam logic [15:0] BANK1_BASE = 16'h8000;
  function automatic logic [15:0] bank_base(input logic b);
    return b ? BANK1_BASE : BANK0_BASE;
  endfunction
endpackage

// File: rtl/output_bank_tracker.sv
// output_bank_tracker: bank_full flags (i_release frees, i_set marks i_set_bank full), preferred-bank pointer, o_sel_bank/o_any_free free-bank choice
module output_bank_tracker
  import output_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_release,
  input  logic       i_set,
  input  logic       i_set_bank,
  output logic [1:0] o_full,
  output logic       o_any_free,
  output logic       o_sel_bank
);
  logic [1:0] r_full;
  logic       r_pref;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_full <= 2'b00;
      r_pref <= 1'b0;
    end else begin
      r_full <= (r_full & ~i_release) | (i_set ? (i_set_bank ? 2'b10 : 2'b01) : 2'b00);
      if (i_set) r_pref <= ~i_set_bank;
    end
  end
  assign o_full     = r_full;
  assign o_any_free = ~&r_full;
  assign o_sel_bank = r_full[r_pref] ? ~r_pref : r_pref;
endmodule

// File: rtl/output_bank_ctrl.sv
// output_bank_ctrl: frame handshake (i_frame_req/o_frame_ack), byte streaming to packer (o_store_start/o_store_bank/o_result_ready), double-bank commit (o_bank_full/o_frame_done/o_frame_bank), sticky o_err_gap
module output_bank_ctrl
  import output_pkg::*;
#(
  parameter int BYTES_PER_FRAME = BYTES_PER_FRAME_DEF,
  parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_req,
  output logic       o_frame_ack,
  input  logic       i_result_valid,
  output logic       o_result_ready,
  output logic       o_store_start,
  output logic       o_store_bank,
  output logic [1:0] o_bank_full,
  input  logic [1:0] i_bank_release,
  output logic       o_frame_done,
  output logic       o_frame_bank,
  output logic       o_err_gap
);
  localparam int CW = $clog2(BYTES_PER_FRAME);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_FRAME - 1);
  localparam logic [FW-1:0] LAST_FLUSH = FW'(FLUSH_CYCLES - 1);
  state_t        r_state, w_next;
  logic [CW-1:0] r_byte_cnt;
  logic [FW-1:0] r_flush_cnt;
  logic          r_store_start, r_ack, r_done, r_store_bank, r_frame_bank, r_err_gap;
  logic          w_any_free, w_sel_bank;
  output_bank_tracker u_tracker (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_release  (i_bank_release),
    .i_set      (r_done),
    .i_set_bank (r_store_bank),
    .o_full     (o_bank_full),
    .o_any_free (w_any_free),
    .o_sel_bank (w_sel_bank)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = i_frame_req ? (w_any_free ? S_ARM : S_WAIT_BANK) : S_IDLE;
      S_WAIT_BANK: w_next = w_any_free ? S_ARM : S_WAIT_BANK;
      S_ARM:       w_next = S_STREAM;
      S_STREAM:    w_next = !i_result_valid ? S_ABORT : (r_byte_cnt == LAST_BYTE ? S_FLUSH : S_STREAM);
      S_FLUSH:     w_next = r_flush_cnt == LAST_FLUSH ? S_DONE : S_FLUSH;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_byte_cnt    <= '0;
      r_flush_cnt   <= '0;
      r_store_start <= 1'b0;
      r_ack         <= 1'b0;
      r_done        <= 1'b0;
      r_store_bank  <= 1'b0;
      r_frame_bank  <= 1'b0;
      r_err_gap     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_store_start <= w_next == S_STREAM;
      r_ack         <= w_next == S_ARM;
      r_done        <= w_next == S_DONE;
      if (w_next == S_ARM) r_store_bank <= w_sel_bank;
      if (w_next == S_DONE) r_frame_bank <= r_store_bank;
      r_byte_cnt    <= r_state == S_ARM ? '0 : (r_state == S_STREAM && i_result_valid) ? r_byte_cnt + 1'b1 : r_byte_cnt;
      r_flush_cnt   <= r_state == S_FLUSH ? r_flush_cnt + 1'b1 : '0;
      if (r_state == S_STREAM && !i_result_valid) r_err_gap <= 1'b1;
    end
  end
  assign o_frame_ack    = r_ack;
  assign o_result_ready = r_store_start;
  assign o_store_start  = r_store_start;
  assign o_store_bank   = r_store_bank;
  assign o_frame_done   = r_done;
  assign o_frame_bank   = r_frame_bank;
  assign o_err_gap      = r_err_gap;
endmodule
